// File: rtl/alu_share_arb.sv
// alu_share_arb
//   Shares one combinational ALU between two requesters through a two-stage
//   pipeline: an issue register that drives the ALU operands, and a response
//   register that captures the ALU result for the owning requester.
//   Requester 0 (core EX) has priority. Requester 1 (SIMD/coprocessor) is
//   forced through after STARVE_MAX consecutive lost arbitrations.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   req0_* / req1_*          valid/ready request channels with operands and op
//   alu_s1, alu_s2, alu_op   issue-register contents driven to the shared ALU
//   alu_result               combinational ALU result for the current alu_*
//   rsp0_* / rsp1_*          valid/ready response channels, payload on rsp_data
//   busy                     issue or response stage holds an entry
module alu_share_arb #(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_s1,
  input  logic [DATA_W-1:0] req0_s2,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_s1,
  input  logic [DATA_W-1:0] req1_s2,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_s1,
  output logic [DATA_W-1:0] alu_s2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic       iss_v;
  logic       iss_own;
  logic       rsp_v;
  logic       rsp_own;
  logic [3:0] starve_cnt;

  logic rsp_drain;
  logic rsp_can_load;
  logic iss_adv;
  logic iss_can_accept;
  logic grant0;
  logic grant1;
  logic accept;

  // Saturating increment of the starvation counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    sat_inc = (cnt >= STARVE_LIM) ? STARVE_LIM : cnt + 4'd1;
  endfunction

  // Handshake and arbitration
  assign rsp_drain      = rsp_v & (rsp_own ? rsp1_ready : rsp0_ready);
  assign rsp_can_load   = ~rsp_v | rsp_drain;
  assign iss_adv        = iss_v & rsp_can_load;
  assign iss_can_accept = ~iss_v | iss_adv;

  // Requester 0 wins unless requester 1 has lost STARVE_MAX times in a row.
  assign grant1 = req1_valid & (~req0_valid | (starve_cnt == STARVE_LIM));
  assign grant0 = req0_valid & ~grant1;

  assign req0_ready = grant0 & iss_can_accept;
  assign req1_ready = grant1 & iss_can_accept;
  assign accept     = req0_ready | req1_ready;

  assign rsp0_valid = rsp_v & ~rsp_own;
  assign rsp1_valid = rsp_v & rsp_own;
  assign busy       = iss_v | rsp_v;

  // Issue stage: holds the accepted operation while the ALU evaluates it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_v   <= 1'b0;
      iss_own <= 1'b0;
      alu_s1  <= '0;
      alu_s2  <= '0;
      alu_op  <= '0;
    end else if (accept) begin
      iss_v   <= 1'b1;
      iss_own <= req1_ready;
      alu_s1  <= req1_ready ? req1_s1 : req0_s1;
      alu_s2  <= req1_ready ? req1_s2 : req0_s2;
      alu_op  <= req1_ready ? req1_op : req0_op;
    end else if (iss_adv) begin
      iss_v <= 1'b0;
    end
  end

  // Response stage: captures the ALU result and presents it to its owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_v    <= 1'b0;
      rsp_own  <= 1'b0;
      rsp_data <= '0;
    end else if (iss_adv) begin
      rsp_v    <= 1'b1;
      rsp_own  <= iss_own;
      rsp_data <= alu_result;
    end else if (rsp_drain) begin
      rsp_v <= 1'b0;
    end
  end

  // Starvation counter: counts cycles requester 1 waits while requester 0 is served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (req1_ready || !req1_valid) begin
      starve_cnt <= 4'd0;
    end else if (req0_ready) begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width.
REQ-002 Parameter OP_W, default 5, ALU opcode width.
REQ-003 Parameter STARVE_MAX, default 4, consecutive lost arbitrations before requester 1 is forced; legal range 1-15.
REQ-004 Ports are as follows, one per line, in the form name, direction, width, meaning:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- req0_valid, in, 1, requester 0 (core EX) has an operation.
- req0_ready, out, 1, requester 0 operation accepted this cycle.
- req0_s1, in, DATA_W, requester 0 operand 1.
- req0_s2, in, DATA_W, requester 0 operand 2.
- req0_op, in, OP_W, requester 0 opcode.
- req1_valid, in, 1, requester 1 (SIMD/coprocessor) has an operation.
- req1_ready, out, 1, requester 1 operation accepted this cycle.
- req1_s1, in, DATA_W, requester 1 operand 1.
- req1_s2, in, DATA_W, requester 1 operand 2.
- req1_op, in, OP_W, requester 1 opcode.
- alu_s1, out, DATA_W, issue-register operand 1 driven to the shared ALU.
- alu_s2, out, DATA_W, issue-register operand 2 driven to the shared ALU.
- alu_op, out, OP_W, issue-register opcode driven to the shared ALU.
- alu_result, in, DATA_W, combinational ALU result for the current alu_* values.
- rsp0_valid, out, 1, result for requester 0 available.
- rsp0_ready, in, 1, requester 0 takes the result.
- rsp1_valid, out, 1, result for requester 1 available.
- rsp1_ready, in, 1, requester 1 takes the result.
- rsp_data, out, DATA_W, result payload shared by both response channels.
- busy, out, 1, issue or response stage holds a valid entry.

Function
REQ-005 Two-stage pipeline: issue register (iss_v, iss_own, operands, op) feeds ALU; response register (rsp_v, rsp_own, rsp_data) captures alu_result.
REQ-006 rsp0_valid SHALL be rsp_v & ~rsp_own, and rsp1_valid SHALL be rsp_v & rsp_own.
REQ-007 rsp_drain SHALL be rsp_v & (rsp_own ? rsp1_ready : rsp0_ready).
REQ-008 Response stage can load when ~rsp_v | rsp_drain; iss_adv = iss_v & that condition; on iss_adv the response register loads alu_result and iss_own, and rsp_v is set.
REQ-009 When the response drains with no iss_adv, rsp_v SHALL clear; rsp_data holds its value while rsp_v is high and not drained.
REQ-010 Issue stage can accept when ~iss_v | iss_adv.
REQ-011 Arbitration, evaluated combinationally each cycle:
- grant1 = req1_valid & (~req0_valid | starve_cnt == STARVE_MAX).
- grant0 = req0_valid & ~grant1.
REQ-012 reqN_ready SHALL be grantN & issue-stage-can-accept; no ready depends on the same requester's valid beyond the grant term.
REQ-013 On an accepted request the issue register loads that requester's s1/s2/op, sets iss_own to N and sets iss_v; with iss_adv and no accept, iss_v clears.
REQ-014 starve_cnt (4 bits) SHALL:
- increment, saturating at STARVE_MAX, when req1_valid & req0_ready occur in the same cycle;
- clear when req1_ready is high or req1_valid is low;
- otherwise hold.
REQ-015 Latency: request accepted in cycle N -> alu_* driven in cycle N+1 -> rsp valid in cycle N+2; throughput is one operation per cycle with no stalls.
REQ-016 Back-pressure: if rsp_v is held and not drained, iss holds, then both readies go low; no operation is dropped or duplicated.
REQ-017 Ordering: responses SHALL emerge in acceptance order; each requester sees only its own results.
REQ-018 busy = iss_v | rsp_v.

Reset
REQ-019 While rst_n is low, iss_v, rsp_v, iss_own, rsp_own and starve_cnt SHALL be 0, and alu_s1, alu_s2, alu_op and rsp_data SHALL be 0.
REQ-020 Assertion of rst_n mid-operation discards all in-flight entries immediately; req/rsp valid outputs are low in that same cycle; the first acceptance is possible on the first clk edge after deassertion.

Verification
REQ-021 Bench SHALL cover the following directed scenarios:
- Only req0 valid, op ADD with s1=5, s2=7, rsp0_ready=1 -> req0_ready cycle 0, alu_s1=5 in cycle 1, rsp0_valid with rsp_data=12 in cycle 2, rsp1_valid=0 throughout.
- Both requesters valid continuously, STARVE_MAX=4, rsp ready high -> grant pattern 0,0,0,0,1 repeating; starve_cnt reads 0..4 then 0.
- rsp0_ready held low for 3 cycles with req0 streaming -> rsp0_valid stays high with rsp_data stable; req0_ready drops the cycle after iss fills; resumes with no lost or duplicated result.
- Alternating req0/req1 single ops, rsp ready high -> rsp0_valid/rsp1_valid alternate in acceptance order with the correct owner per result.
- rst_n pulsed low while iss_v=1 and rsp_v=1 -> busy=0 and both rsp valids 0 in that cycle; no response appears afterwards for the discarded operations.
- Only req1 valid with req0 idle -> req1_ready every cycle and starve_cnt stays 0.
